// File: rtl/tcm_arb_ctrl_if.sv
// Requestor-side bundle of the TCM arbiter: per-port command and response channels,
// with per-port fields packed side by side (port i at [i*W +: W]).
interface tcm_arb_ctrl_if #(
  parameter int NPORT = 2,
  parameter int AW    = 16,
  parameter int DW    = 32,
  parameter int MW    = 4
);
  logic [NPORT-1:0]    cmd_valid;
  logic [NPORT-1:0]    cmd_ready;
  logic [NPORT-1:0]    cmd_read;
  logic [NPORT*AW-1:0] cmd_addr;
  logic [NPORT*DW-1:0] cmd_wdata;
  logic [NPORT*MW-1:0] cmd_wmask;
  logic [NPORT-1:0]    rsp_valid;
  logic [NPORT-1:0]    rsp_ready;
  logic [DW-1:0]       rsp_rdata;

  modport master (
    output cmd_valid, cmd_read, cmd_addr, cmd_wdata, cmd_wmask, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  cmd_valid, cmd_read, cmd_addr, cmd_wdata, cmd_wmask, rsp_ready,
    output cmd_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/tcm_arb_ctrl.sv
// Round-robin arbiter of NPORT requestors onto one single-port TCM SRAM, with one
// pipelined access per cycle and a one-entry response buffer for stalled responses.
module tcm_arb_ctrl #(
  parameter int NPORT = 2,
  parameter int AW    = 16,
  parameter int DW    = 32,
  parameter int MW    = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  tcm_arb_ctrl_if.slave  req,
  output logic           ram_cs,
  output logic           ram_we,
  output logic [AW-1:0]  ram_addr,
  output logic [MW-1:0]  ram_wem,
  output logic [DW-1:0]  ram_din,
  input  logic [DW-1:0]  ram_dout,
  output logic           tcm_active
);

  localparam int PW = (NPORT > 1) ? $clog2(NPORT) : 1;

  typedef enum logic [1:0] {IDLE, RSP, HOLD} state_t;

  state_t        state;
  logic [PW-1:0] owner;
  logic [PW-1:0] rr_ptr;
  logic          rsp_is_read;
  logic [DW-1:0] hold_q;

  logic          owner_ready;
  logic          can_issue;
  logic          grant_valid;
  logic [PW-1:0] grant;
  logic [DW-1:0] rsp_data;

  assign owner_ready = req.rsp_ready[owner];
  assign can_issue   = rst_n && ((state == IDLE) || owner_ready);

  // Search starts one past the last winner so every valid port is served within NPORT grants.
  always_comb begin
    logic [PW:0] idx;
    grant_valid = 1'b0;
    grant       = '0;
    idx         = '0;
    if (can_issue) begin
      for (int k = 1; k <= NPORT; k++) begin
        idx = {1'b0, rr_ptr} + (PW+1)'(k);
        if (int'(idx) >= NPORT) idx = idx - (PW+1)'(NPORT);
        if (!grant_valid && req.cmd_valid[idx[PW-1:0]]) begin
          grant_valid = 1'b1;
          grant       = idx[PW-1:0];
        end
      end
    end
  end

  always_comb begin
    ram_cs   = grant_valid;
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_wem  = '0;
    ram_din  = '0;
    if (grant_valid) begin
      ram_we   = ~req.cmd_read[grant];
      ram_addr = req.cmd_addr[grant*AW +: AW];
      ram_wem  = req.cmd_wmask[grant*MW +: MW];
      ram_din  = req.cmd_wdata[grant*DW +: DW];
    end
  end

  // Write responses carry zero data; the SRAM output is only meaningful after a read.
  always_comb begin
    rsp_data = '0;
    if (state == HOLD)                    rsp_data = hold_q;
    else if (state == RSP && rsp_is_read) rsp_data = ram_dout;
  end

  always_comb begin
    req.cmd_ready = '0;
    req.rsp_valid = '0;
    for (int i = 0; i < NPORT; i++) begin
      req.cmd_ready[i] = grant_valid && (grant == PW'(i));
      req.rsp_valid[i] = (state != IDLE) && (owner == PW'(i));
    end
  end

  assign req.rsp_rdata = rsp_data;
  assign tcm_active    = rst_n && ((|req.cmd_valid) || (state != IDLE));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      rr_ptr      <= PW'(NPORT-1);
      owner       <= '0;
      rsp_is_read <= 1'b0;
      hold_q      <= '0;
    end else if (grant_valid) begin
      state       <= RSP;
      rr_ptr      <= grant;
      owner       <= grant;
      rsp_is_read <= req.cmd_read[grant];
    end else if (state == RSP && !owner_ready) begin
      state  <= HOLD;
      hold_q <= rsp_data;
    end else if (state != IDLE && owner_ready) begin
      state <= IDLE;
    end
  end

endmodule

// File: tb/tb_tcm_arb_ctrl.sv
// Directed bench for tcm_arb_ctrl: a cycle table plus hand sequences for hold, reset and
// streaming, against a behavioural SRAM whose output is garbage unless a read was issued.
module tb_tcm_arb_ctrl;

  localparam int NPORT = 2;
  localparam int AW    = 16;
  localparam int DW    = 32;
  localparam int MW    = 4;

  logic          clk;
  logic          rst_n;
  logic          ram_cs;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [MW-1:0] ram_wem;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;
  logic          tcm_active;

  logic [DW-1:0] mem [0:255];
  bit            mem_init_done;

  int checks;
  int failures;

  tcm_arb_ctrl_if #(.NPORT(NPORT), .AW(AW), .DW(DW), .MW(MW)) bus ();

  tcm_arb_ctrl #(.NPORT(NPORT), .AW(AW), .DW(DW), .MW(MW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (bus.slave),
    .ram_cs     (ram_cs),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wem    (ram_wem),
    .ram_din    (ram_din),
    .ram_dout   (ram_dout),
    .tcm_active (tcm_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Preload: 0x10, 0x20 and words 0..7 (word 5 left at zero for the masked-write test).
  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 256; i++) mem[i] = '0;
      mem[16] = 32'hDEAD_BEEF;
      mem[32] = 32'h1234_5678;
      for (int i = 0; i < 8; i++) if (i != 5) mem[i] = 32'h1111_0000 + i;
      mem_init_done = 1'b1;
    end
    if (ram_cs && ram_we)
      for (int b = 0; b < MW; b++)
        if (ram_wem[b]) mem[ram_addr[7:0]][8*b +: 8] = ram_din[8*b +: 8];
    ram_dout <= (ram_cs && !ram_we) ? mem[ram_addr[7:0]] : 32'hBAD0_BAD0;
  end

  typedef struct {
    string       name;
    logic        rst_n;
    logic [1:0]  valid;
    logic [1:0]  read;
    logic [15:0] addr0;
    logic [15:0] addr1;
    logic [31:0] wdata0;
    logic [3:0]  wmask0;
    logic [1:0]  rdy;
    logic [1:0]  e_ready;
    logic        e_cs;
    logic        e_we;
    logic [15:0] e_addr;
    logic [3:0]  e_wem;
    logic [31:0] e_din;
    logic [1:0]  e_rsp_valid;
    logic [31:0] e_rdata;
    logic        e_active;
    logic        chk_rsp;
  } vec_t;

  function automatic vec_t mk(string name, logic r, logic [1:0] valid, logic [1:0] read,
                              logic [15:0] a0, logic [15:0] a1, logic [31:0] wd0,
                              logic [3:0] wm0, logic [1:0] rdy, logic [1:0] e_ready,
                              logic e_cs, logic e_we, logic [15:0] e_addr, logic [3:0] e_wem,
                              logic [31:0] e_din, logic [1:0] e_rv, logic [31:0] e_rdata,
                              logic e_active, logic chk_rsp);
    vec_t v;
    v.name = name;   v.rst_n = r;       v.valid = valid;    v.read = read;
    v.addr0 = a0;    v.addr1 = a1;      v.wdata0 = wd0;     v.wmask0 = wm0;
    v.rdy = rdy;     v.e_ready = e_ready; v.e_cs = e_cs;    v.e_we = e_we;
    v.e_addr = e_addr; v.e_wem = e_wem; v.e_din = e_din;    v.e_rsp_valid = e_rv;
    v.e_rdata = e_rdata; v.e_active = e_active; v.chk_rsp = chk_rsp;
    return v;
  endfunction

  task automatic check_field(string name, string field, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s.%s actual=%0h expected=%0h", name, field, act, exp);
    end
  endtask

  task automatic apply_stimulus(vec_t v);
    rst_n             = v.rst_n;
    bus.cmd_valid     = v.valid;
    bus.cmd_read      = v.read;
    bus.cmd_addr      = {v.addr1, v.addr0};
    bus.cmd_wdata     = {32'h0, v.wdata0};
    bus.cmd_wmask     = {4'h0, v.wmask0};
    bus.rsp_ready     = v.rdy;
  endtask

  task automatic check_output(vec_t v);
    check_field(v.name, "cmd_ready", 32'(bus.cmd_ready), 32'(v.e_ready));
    check_field(v.name, "ram_cs", 32'(ram_cs), 32'(v.e_cs));
    check_field(v.name, "ram_we", 32'(ram_we), 32'(v.e_we));
    check_field(v.name, "ram_addr", 32'(ram_addr), 32'(v.e_addr));
    check_field(v.name, "ram_wem", 32'(ram_wem), 32'(v.e_wem));
    check_field(v.name, "ram_din", ram_din, v.e_din);
    check_field(v.name, "tcm_active", 32'(tcm_active), 32'(v.e_active));
    if (v.chk_rsp) begin
      check_field(v.name, "rsp_valid", 32'(bus.rsp_valid), 32'(v.e_rsp_valid));
      check_field(v.name, "rsp_rdata", bus.rsp_rdata, v.e_rdata);
    end
  endtask

  // One cycle: drive after the rising edge, compare on the falling edge.
  task automatic run_vec(vec_t v);
    apply_stimulus(v);
    @(negedge clk);
    check_output(v);
    @(posedge clk);
    #1;
  endtask

  vec_t table_vecs[$];

  function automatic logic [31:0] stream_word(int i);
    return (i == 5) ? 32'h0000_CCDD : 32'h1111_0000 + 32'(i);
  endfunction

  initial begin
    checks        = 0;
    failures      = 0;
    mem_init_done = 1'b0;

    // name  rst valid read  a0     a1     wdata0        wm   rdy | ready cs we addr   wem  din           rv    rdata          act chk
    table_vecs.push_back(mk("rst_idle", 0, 2'b01, 2'b01, 16'h10, 16'h0, 32'h0, 4'h0, 2'b11, 2'b00, 0, 0, 16'h0, 4'h0, 32'h0, 2'b00, 32'h0, 0, 1));
    table_vecs.push_back(mk("t1_issue", 1, 2'b01, 2'b01, 16'h10, 16'h0, 32'h0, 4'h0, 2'b11, 2'b01, 1, 0, 16'h10, 4'h0, 32'h0, 2'b00, 32'h0, 1, 1));
    table_vecs.push_back(mk("t1_rsp", 1, 2'b00, 2'b00, 16'h0, 16'h0, 32'h0, 4'h0, 2'b11, 2'b00, 0, 0, 16'h0, 4'h0, 32'h0, 2'b01, 32'hDEAD_BEEF, 1, 1));
    table_vecs.push_back(mk("t2_rst", 0, 2'b00, 2'b00, 16'h0, 16'h0, 32'h0, 4'h0, 2'b11, 2'b00, 0, 0, 16'h0, 4'h0, 32'h0, 2'b00, 32'h0, 0, 1));
    table_vecs.push_back(mk("t2_g0", 1, 2'b11, 2'b11, 16'h10, 16'h20, 32'h0, 4'h0, 2'b11, 2'b01, 1, 0, 16'h10, 4'h0, 32'h0, 2'b00, 32'h0, 1, 1));
    table_vecs.push_back(mk("t2_g1", 1, 2'b11, 2'b11, 16'h10, 16'h20, 32'h0, 4'h0, 2'b11, 2'b10, 1, 0, 16'h20, 4'h0, 32'h0, 2'b01, 32'hDEAD_BEEF, 1, 1));
    table_vecs.push_back(mk("t2_g0b", 1, 2'b11, 2'b11, 16'h10, 16'h20, 32'h0, 4'h0, 2'b11, 2'b01, 1, 0, 16'h10, 4'h0, 32'h0, 2'b10, 32'h1234_5678, 1, 1));
    table_vecs.push_back(mk("t2_g1b", 1, 2'b11, 2'b11, 16'h10, 16'h20, 32'h0, 4'h0, 2'b11, 2'b10, 1, 0, 16'h20, 4'h0, 32'h0, 2'b01, 32'hDEAD_BEEF, 1, 1));
    table_vecs.push_back(mk("t2_drain", 1, 2'b00, 2'b00, 16'h0, 16'h0, 32'h0, 4'h0, 2'b11, 2'b00, 0, 0, 16'h0, 4'h0, 32'h0, 2'b10, 32'h1234_5678, 1, 1));
    table_vecs.push_back(mk("t4_write", 1, 2'b01, 2'b00, 16'h5, 16'h0, 32'hAABB_CCDD, 4'b0011, 2'b11, 2'b01, 1, 1, 16'h5, 4'b0011, 32'hAABB_CCDD, 2'b00, 32'h0, 1, 1));
    table_vecs.push_back(mk("t4_read", 1, 2'b01, 2'b01, 16'h5, 16'h0, 32'h0, 4'h0, 2'b11, 2'b01, 1, 0, 16'h5, 4'h0, 32'h0, 2'b01, 32'h0, 1, 1));
    table_vecs.push_back(mk("t4_rdrsp", 1, 2'b00, 2'b00, 16'h0, 16'h0, 32'h0, 4'h0, 2'b11, 2'b00, 0, 0, 16'h0, 4'h0, 32'h0, 2'b01, 32'h0000_CCDD, 1, 1));
    table_vecs.push_back(mk("idle", 1, 2'b00, 2'b00, 16'h0, 16'h0, 32'h0, 4'h0, 2'b11, 2'b00, 0, 0, 16'h0, 4'h0, 32'h0, 2'b00, 32'h0, 0, 1));

    apply_stimulus(table_vecs[0]);
    repeat (2) @(posedge clk);
    #1;

    foreach (table_vecs[i]) run_vec(table_vecs[i]);

    // Port 1 response stalled three cycles: buffered data must persist with SRAM output garbage.
    run_vec(mk("t3_issue", 1, 2'b10, 2'b10, 16'h10, 16'h20, 32'h0, 4'h0, 2'b00, 2'b10, 1, 0, 16'h20, 4'h0, 32'h0, 2'b00, 32'h0, 1, 1));
    for (int c = 0; c < 3; c++)
      run_vec(mk($sformatf("t3_stall%0d", c), 1, 2'b11, 2'b11, 16'h10, 16'h20, 32'h0, 4'h0, 2'b00, 2'b00, 0, 0, 16'h0, 4'h0, 32'h0, 2'b10, 32'h1234_5678, 1, 1));
    run_vec(mk("t3_release", 1, 2'b11, 2'b11, 16'h10, 16'h20, 32'h0, 4'h0, 2'b10, 2'b01, 1, 0, 16'h10, 4'h0, 32'h0, 2'b10, 32'h1234_5678, 1, 1));
    run_vec(mk("t3_next", 1, 2'b00, 2'b00, 16'h0, 16'h0, 32'h0, 4'h0, 2'b11, 2'b00, 0, 0, 16'h0, 4'h0, 32'h0, 2'b01, 32'hDEAD_BEEF, 1, 1));

    // Reset lands while a port-1 response is pending and unacknowledged.
    run_vec(mk("t5_issue", 1, 2'b10, 2'b10, 16'h10, 16'h20, 32'h0, 4'h0, 2'b00, 2'b10, 1, 0, 16'h20, 4'h0, 32'h0, 2'b00, 32'h0, 1, 1));
    run_vec(mk("t5_rst", 0, 2'b11, 2'b11, 16'h10, 16'h20, 32'h0, 4'h0, 2'b00, 2'b00, 0, 0, 16'h0, 4'h0, 32'h0, 2'b00, 32'h0, 0, 0));
    run_vec(mk("t5_post", 1, 2'b11, 2'b11, 16'h10, 16'h20, 32'h0, 4'h0, 2'b01, 2'b01, 1, 0, 16'h10, 4'h0, 32'h0, 2'b00, 32'h0, 1, 1));
    run_vec(mk("t5_rsp", 1, 2'b00, 2'b00, 16'h0, 16'h0, 32'h0, 4'h0, 2'b11, 2'b00, 0, 0, 16'h0, 4'h0, 32'h0, 2'b01, 32'hDEAD_BEEF, 1, 1));

    // Single requestor streaming reads of words 0..7 with no bubbles.
    for (int i = 0; i <= 8; i++) begin
      logic       act;
      logic [1:0] rv;
      act = (i < 8);
      rv  = (i > 0) ? 2'b01 : 2'b00;
      run_vec(mk($sformatf("t6_c%0d", i), 1, {1'b0, act}, {1'b0, act}, act ? 16'(i) : 16'h0, 16'h0,
                 32'h0, 4'h0, 2'b11, {1'b0, act}, act, 0, act ? 16'(i) : 16'h0, 4'h0, 32'h0,
                 rv, (i > 0) ? stream_word(i-1) : 32'h0, 1, 1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
